// File: rtl/chrom_serial_if.sv
// chrom_serial_if: CPU/circuit-facing signal bundle of chrom_serial_processor
interface chrom_serial_if #(
  parameter int CHROM_W = 32,
  parameter int FIT_W = 16
);
  logic start;
  logic [CHROM_W-1:0] chrom_in;
  logic ser_in;
  logic ser_out;
  logic ser_valid;
  logic busy;
  logic [FIT_W-1:0] fitness;
  logic done_processing;
  modport master (
    output start, chrom_in, ser_in,
    input ser_out, ser_valid, busy, fitness, done_processing
  );
  modport slave (
    input start, chrom_in, ser_in,
    output ser_out, ser_valid, busy, fitness, done_processing
  );
endinterface

// File: rtl/chrom_serial_processor.sv
// chrom_serial_processor: bit-serial chromosome shifter with saturating fitness count and sticky done (CHROM_SER_MSB_FIRST_EN selects MSB-first)
module chrom_serial_processor #(
  parameter int CHROM_W = 32,
  parameter int FIT_W = 16,
  parameter int BIT_DIV = 4
) (
  input logic clk,
  input logic reset_n,
  chrom_serial_if.slave bus
);
  localparam int BW = $clog2(CHROM_W);
  localparam int DW = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state_q, state_d;
  logic [CHROM_W-1:0] shreg_q, shreg_d, shreg_nx;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic [FIT_W-1:0] fitness_q, fitness_d;
  logic done_q, done_d;
  logic start_q;
  logic cur_bit;
  logic shifting;
`ifdef CHROM_SER_MSB_FIRST_EN
  assign cur_bit = shreg_q[CHROM_W-1];
  assign shreg_nx = {shreg_q[CHROM_W-2:0], 1'b0};
`else
  assign cur_bit = shreg_q[0];
  assign shreg_nx = {1'b0, shreg_q[CHROM_W-1:1]};
`endif
  assign shifting = (state_q == SHIFT);
  assign bus.ser_out = shifting & cur_bit;
  assign bus.ser_valid = shifting;
  assign bus.busy = shifting;
  assign bus.fitness = fitness_q;
  assign bus.done_processing = done_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      bit_cnt_q <= '0;
      div_cnt_q <= '0;
      fitness_q <= '0;
      done_q <= 1'b0;
      start_q <= 1'b1;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      div_cnt_q <= div_cnt_d;
      fitness_q <= fitness_d;
      done_q <= done_d;
      start_q <= bus.start;
    end
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    bit_cnt_d = bit_cnt_q;
    div_cnt_d = div_cnt_q;
    fitness_d = fitness_q;
    done_d = done_q;
    if (bus.start && !start_q && !shifting) begin
      state_d = SHIFT;
      shreg_d = bus.chrom_in;
      bit_cnt_d = '0;
      div_cnt_d = '0;
      fitness_d = '0;
      done_d = 1'b0;
    end else if (shifting) begin
      if (div_cnt_q == DW'(BIT_DIV - 1)) begin
        div_cnt_d = '0;
        fitness_d = (bus.ser_in && !(&fitness_q)) ? fitness_q + FIT_W'(1) : fitness_q;
        shreg_d = shreg_nx;
        bit_cnt_d = bit_cnt_q + BW'(1);
        state_d = (bit_cnt_q == BW'(CHROM_W - 1)) ? DONE : SHIFT;
        done_d = (bit_cnt_q == BW'(CHROM_W - 1));
      end else begin
        div_cnt_d = div_cnt_q + DW'(1);
      end
    end
  end
endmodule

// File: tb/tb_chrom_serial_processor.sv
// tb_chrom_serial_processor: directed checks of default and small-parameter chrom_serial_processor
module tb_chrom_serial_processor;
  logic clk;
  logic reset_n;
  logic loop;
  logic ser_drv;
  int nchk;
  int nerr;
  logic [31:0] cv;
  logic [15:0] c1;
  chrom_serial_if #(.CHROM_W(32), .FIT_W(16)) if0 ();
  chrom_serial_if #(.CHROM_W(16), .FIT_W(3)) if1 ();
  chrom_serial_processor #(.CHROM_W(32), .FIT_W(16), .BIT_DIV(4)) dut0 (
    .clk(clk), .reset_n(reset_n), .bus(if0.slave)
  );
  chrom_serial_processor #(.CHROM_W(16), .FIT_W(3), .BIT_DIV(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(if1.slave)
  );
  assign if0.ser_in = loop ? if0.ser_out : ser_drv;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic bit0(input logic [31:0] v, input int i);
`ifdef CHROM_SER_MSB_FIRST_EN
    return v[31-i];
`else
    return v[i];
`endif
  endfunction
  function automatic logic bit1(input logic [15:0] v, input int i);
`ifdef CHROM_SER_MSB_FIRST_EN
    return v[15-i];
`else
    return v[i];
`endif
  endfunction
  initial begin
    nchk = 0;
    nerr = 0;
    reset_n = 1'b0;
    loop = 1'b0;
    ser_drv = 1'b0;
    if0.start = 1'b0;
    if0.chrom_in = '0;
    if1.start = 1'b0;
    if1.chrom_in = '0;
    if1.ser_in = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("idle_ser_out", if0.ser_out, 0);
    chk("idle_ser_valid", if0.ser_valid, 0);
    chk("idle_busy", if0.busy, 0);
    chk("idle_fitness", if0.fitness, 0);
    chk("idle_done", if0.done_processing, 0);
    chk("idle_busy_small", if1.busy, 0);
    cv = 32'h0000_0005;
    if0.chrom_in = cv;
    ser_drv = 1'b1;
    if0.start = 1'b1;
    for (int j = 0; j < 128; j++) begin
      @(negedge clk);
      if (j == 2) if0.chrom_in = 32'hFFFF_FFFF;
      chk($sformatf("run1_ser_out_%0d", j), if0.ser_out, bit0(cv, j / 4));
      if (j == 0 || j == 127) chk($sformatf("run1_busy_%0d", j), if0.busy, 1);
      if (j == 127) chk("run1_done_early", if0.done_processing, 0);
    end
    @(negedge clk);
    chk("run1_done", if0.done_processing, 1);
    chk("run1_fitness", if0.fitness, 32);
    chk("run1_busy_after", if0.busy, 0);
    chk("run1_valid_after", if0.ser_valid, 0);
    chk("run1_ser_out_after", if0.ser_out, 0);
    repeat (20) @(negedge clk);
    chk("held_start_busy", if0.busy, 0);
    chk("held_start_done", if0.done_processing, 1);
    chk("held_start_fitness", if0.fitness, 32);
    if0.start = 1'b0;
    @(negedge clk);
    cv = 32'hF0F0_00FF;
    if0.chrom_in = cv;
    loop = 1'b1;
    if0.start = 1'b1;
    for (int j = 0; j < 128; j++) begin
      @(negedge clk);
      if (j == 0) chk("run2_done_cleared", if0.done_processing, 0);
      if (j == 0) chk("run2_fitness_cleared", if0.fitness, 0);
      if (j % 4 == 0 && j < 32) chk($sformatf("run2_ser_out_%0d", j), if0.ser_out, bit0(cv, j / 4));
    end
    @(negedge clk);
    chk("run2_done", if0.done_processing, 1);
    chk("run2_fitness", if0.fitness, 16);
    if0.start = 1'b0;
    loop = 1'b0;
    ser_drv = 1'b0;
    @(negedge clk);
    if0.chrom_in = '0;
    if0.start = 1'b1;
    for (int j = 0; j < 128; j++) begin
      @(negedge clk);
      if (j == 0) chk("run3_done_cleared", if0.done_processing, 0);
      if (j == 0) chk("run3_fitness_cleared", if0.fitness, 0);
      if (j == 50) if0.start = 1'b0;
      if (j == 52) if0.start = 1'b1;
      if (j == 60) if0.start = 1'b0;
      if (j == 127) chk("run3_done_early", if0.done_processing, 0);
    end
    @(negedge clk);
    chk("run3_done", if0.done_processing, 1);
    chk("run3_fitness", if0.fitness, 0);
    if0.start = 1'b0;
    @(negedge clk);
    if0.chrom_in = 32'hFFFF_FFFF;
    ser_drv = 1'b1;
    if0.start = 1'b1;
    repeat (50) @(negedge clk);
    chk("abort_busy_before", if0.busy, 1);
    reset_n = 1'b0;
    #1;
    chk("abort_busy", if0.busy, 0);
    chk("abort_valid", if0.ser_valid, 0);
    chk("abort_ser_out", if0.ser_out, 0);
    chk("abort_fitness", if0.fitness, 0);
    chk("abort_done", if0.done_processing, 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (200) @(negedge clk);
    chk("no_run_after_reset_busy", if0.busy, 0);
    chk("no_run_after_reset_done", if0.done_processing, 0);
    chk("no_run_after_reset_fitness", if0.fitness, 0);
    if0.start = 1'b0;
    c1 = 16'hA5C3;
    if1.chrom_in = c1;
    if1.ser_in = 1'b1;
    if1.start = 1'b1;
    for (int j = 0; j < 16; j++) begin
      @(negedge clk);
      chk($sformatf("small_ser_out_%0d", j), if1.ser_out, bit1(c1, j));
      if (j == 5) chk("small_fitness_5", if1.fitness, 5);
      if (j == 10) chk("small_fitness_sat", if1.fitness, 7);
      if (j == 15) chk("small_done_early", if1.done_processing, 0);
    end
    @(negedge clk);
    chk("small_done", if1.done_processing, 1);
    chk("small_fitness", if1.fitness, 7);
    chk("small_busy_after", if1.busy, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
    $finish;
  end
endmodule
